// File: rtl/sram_access_pkg.sv
// Shared types and default sizing for the SRAM access master.
package sram_access_pkg;

  localparam int unsigned ADDR_W_DEF     = 14;
  localparam int unsigned DATA_W_DEF     = 48;
  localparam int unsigned RESP_DEPTH_DEF = 4;
  localparam int unsigned BURST_LEN_W    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/sram_access_resp_fifo.sv
// Synchronous response FIFO; depth must be a power of two (>= 2).
module sram_access_resp_fifo #(
  parameter int unsigned depth = 4,
  parameter int unsigned width = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [width-1:0]         data_o,
  output logic [$clog2(depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(depth));

endmodule

// File: rtl/sram_access_master.sv
// Valid/ready request stream to single-port SRAM pins, read data returned via a credited FIFO.
// Optional read bursts are built in when SRAM_MASTER_BURST_EN is defined.
module sram_access_master
  import sram_access_pkg::*;
#(
  parameter int unsigned address_width = ADDR_W_DEF,
  parameter int unsigned data_width    = DATA_W_DEF,
  parameter int unsigned resp_depth    = RESP_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_read_not_write,
  input  logic [address_width-1:0] req_address,
  input  logic [data_width-1:0]    req_write_data,
`ifdef SRAM_MASTER_BURST_EN
  input  logic [BURST_LEN_W-1:0]   req_burst_len,
`endif
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [data_width-1:0]    resp_data,
  output logic                     sram_select,
  output logic                     sram_read_not_write,
  output logic [address_width-1:0] sram_address,
  output logic [data_width-1:0]    sram_write_data,
  input  logic [data_width-1:0]    sram_data_out
);

  localparam int unsigned CNT_W = $clog2(resp_depth) + 1;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] credit_used;
  logic             credit_ok;
  logic             fifo_empty, fifo_full;
  logic             issue_read;
  logic             inflight_q, inflight_d;

  // Credit ignores a same-cycle pop, so the FIFO can never be pushed while full.
  assign credit_used = fifo_count + CNT_W'(inflight_q);
  assign credit_ok   = (credit_used < CNT_W'(resp_depth));
  assign inflight_d  = issue_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight_q <= 1'b0;
    else          inflight_q <= inflight_d;
  end

`ifdef SRAM_MASTER_BURST_EN
  state_e                   state_q, state_d;
  logic [address_width-1:0] burst_addr_q, burst_addr_d;
  logic [BURST_LEN_W-1:0]   beats_left_q, beats_left_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      burst_addr_q <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      beats_left_q <= beats_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    beats_left_d = beats_left_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready && req_read_not_write && (req_burst_len != '0)) begin
          state_d      = BURST;
          burst_addr_d = req_address + address_width'(1);
          beats_left_d = req_burst_len;
        end
      end
      BURST: begin
        if (credit_ok) begin
          burst_addr_d = burst_addr_q + address_width'(1);
          beats_left_d = beats_left_q - BURST_LEN_W'(1);
          if (beats_left_q == BURST_LEN_W'(1)) state_d = IDLE;
        end
      end
    endcase
  end
`endif

  // Pins follow the request combinationally so an accepted beat hits the SRAM in the same cycle.
  always_comb begin
    req_ready           = 1'b0;
    sram_select         = 1'b0;
    sram_read_not_write = 1'b1;
    sram_address        = '0;
    sram_write_data     = '0;
    issue_read          = 1'b0;
    if (reset_n) begin
`ifdef SRAM_MASTER_BURST_EN
      if (state_q == BURST) begin
        sram_select  = credit_ok;
        sram_address = burst_addr_q;
        issue_read   = credit_ok;
      end else
`endif
      begin
        req_ready = req_read_not_write ? credit_ok : 1'b1;
        if (req_valid && req_ready) begin
          sram_select         = 1'b1;
          sram_read_not_write = req_read_not_write;
          sram_address        = req_address;
          sram_write_data     = req_write_data;
          issue_read          = req_read_not_write;
        end
      end
    end
  end

  sram_access_resp_fifo #(
    .depth (resp_depth),
    .width (data_width)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (inflight_q),
    .data_i  (sram_data_out),
    .pop_i   (resp_valid & resp_ready),
    .data_o  (resp_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign resp_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset_n) assert (!(inflight_q && fifo_full));
  end

endmodule

// File: tb/tb_sram_access_master.sv
// Directed bench for sram_access_master with a behavioural SRAM port model.
// Burst scenarios are compiled in when SRAM_MASTER_BURST_EN is defined.
module tb_sram_access_master;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 48;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_read_not_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_write_data;
`ifdef SRAM_MASTER_BURST_EN
  logic [3:0]    req_burst_len;
`endif
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          sram_select;
  logic          sram_read_not_write;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data;
  logic [DW-1:0] sram_data_out;

  logic [DW-1:0] mem [1 << AW];

  int unsigned total;
  int unsigned bad;

  sram_access_master #(
    .address_width (AW),
    .data_width    (DW),
    .resp_depth    (4)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_read_not_write  (req_read_not_write),
    .req_address         (req_address),
    .req_write_data      (req_write_data),
`ifdef SRAM_MASTER_BURST_EN
    .req_burst_len       (req_burst_len),
`endif
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_data           (resp_data),
    .sram_select         (sram_select),
    .sram_read_not_write (sram_read_not_write),
    .sram_address        (sram_address),
    .sram_write_data     (sram_write_data),
    .sram_data_out       (sram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM port: write on select, read data registered for the following cycle.
  always @(posedge clk) begin
    if (sram_select) begin
      if (!sram_read_not_write) mem[sram_address] <= sram_write_data;
      else                      sram_data_out     <= mem[sram_address];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the following negedge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid          = 1'b1;
    req_read_not_write = 1'b0;
    req_address        = a;
    req_write_data     = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int unsigned idx;
    int unsigned rc;
    int unsigned nsel;
    logic        paused;
    logic [AW-1:0] a;

    total = 0;
    bad   = 0;
    reset_n            = 1'b0;
    req_valid          = 1'b1;
    req_read_not_write = 1'b0;
    req_address        = 14'h0123;
    req_write_data     = 48'h55;
    resp_ready         = 1'b1;
`ifdef SRAM_MASTER_BURST_EN
    req_burst_len      = 4'd0;
`endif

    // Reset values
    @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_select", sram_select, 1'b0);
    check("rst_rnw", sram_read_not_write, 1'b1);
    check("rst_addr", sram_address, 0);
    check("rst_wdata", sram_write_data, 0);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);

    // 1: write 0x2A to addr 5, read it back
    req_valid          = 1'b1;
    req_read_not_write = 1'b0;
    req_address        = 14'd5;
    req_write_data     = 48'h2A;
    #1;
    check("t1_wr_ready", req_ready, 1'b1);
    check("t1_wr_select", sram_select, 1'b1);
    check("t1_wr_rnw", sram_read_not_write, 1'b0);
    check("t1_wr_addr", sram_address, 5);
    check("t1_wr_data", sram_write_data, 48'h2A);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("t1_wr_one_cycle", sram_select, 1'b0);
    check("t1_wr_no_resp", resp_valid, 1'b0);
    req_valid          = 1'b1;
    req_read_not_write = 1'b1;
    #1;
    check("t1_rd_ready", req_ready, 1'b1);
    check("t1_rd_rnw", sram_read_not_write, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("t1_rd_lat1", resp_valid, 1'b0);
    @(negedge clk);
    check("t1_rd_lat2", resp_valid, 1'b1);
    check("t1_rd_data", resp_data, 48'h2A);
    @(negedge clk);
    check("t1_popped", resp_valid, 1'b0);

    // 2: back-to-back reads of 0..7 holding addr*3
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'(i * 3));
    req_read_not_write = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      req_valid   = (c < 8);
      req_address = AW'(c);
      #1;
      if (c < 8) check("t2_ready", req_ready, 1'b1);
      if (c >= 2 && c < 10) begin
        check("t2_valid", resp_valid, 1'b1);
        check("t2_data", resp_data, DW'((c - 2) * 3));
      end
      if (c == 10) check("t2_drained", resp_valid, 1'b0);
      @(negedge clk);
    end

    // 3: credit limit with resp_ready low, then drain
    for (int i = 0; i < 6; i++) wr(AW'(16 + i), DW'(256 + i));
    resp_ready         = 1'b0;
    req_read_not_write = 1'b1;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      req_valid   = 1'b1;
      req_address = AW'(16 + idx);
      #1;
      check("t3_ready", req_ready, (c < 4));
      if (c >= 4) begin
        check("t3_hold_valid", resp_valid, 1'b1);
        check("t3_hold_data", resp_data, 48'h100);
      end
      if (req_ready) idx++;
      @(negedge clk);
    end
    check("t3_accepted", idx, 4);
    resp_ready = 1'b1;
    rc = 0;
    for (int c = 0; c < 15; c++) begin
      req_valid   = (idx < 6);
      req_address = AW'(16 + idx);
      #1;
      if (c == 0) check("t3_conservative", req_ready, 1'b0);
      if (resp_valid) begin
        check("t3_data", resp_data, DW'(256 + rc));
        rc++;
      end
      if (req_valid && req_ready) idx++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("t3_all_accepted", idx, 6);
    check("t3_all_returned", rc, 6);

    // 4: reset while a read is in flight
    req_valid          = 1'b1;
    req_read_not_write = 1'b1;
    req_address        = 14'd3;
    #1;
    check("t4_ready", req_ready, 1'b1);
    @(negedge clk);
    reset_n            = 1'b0;
    req_read_not_write = 1'b0;
    #1;
    check("t4_rst_ready", req_ready, 1'b0);
    check("t4_rst_select", sram_select, 1'b0);
    check("t4_rst_valid", resp_valid, 1'b0);
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 1'b0;
    #1;
    check("t4_post_valid0", resp_valid, 1'b0);
    @(negedge clk);
    check("t4_post_valid1", resp_valid, 1'b0);
    req_valid          = 1'b1;
    req_read_not_write = 1'b1;
    req_address        = 14'd7;
    #1;
    check("t4_rd_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("t4_rd_valid", resp_valid, 1'b1);
    check("t4_rd_data", resp_data, 21);
    @(negedge clk);

`ifdef SRAM_MASTER_BURST_EN
    // 5: burst across the top of the address space
    for (int k = 0; k < 4; k++) wr(AW'(14'h3FFE + k), DW'(160 + k));
    req_valid          = 1'b1;
    req_read_not_write = 1'b1;
    req_address        = 14'h3FFE;
    req_burst_len      = 4'd3;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        req_valid     = 1'b0;
        req_burst_len = 4'd0;
      end
      #1;
      a = AW'(14'h3FFE + c);
      if (c < 4) begin
        check("t5_ready", req_ready, (c == 0));
        check("t5_select", sram_select, 1'b1);
        check("t5_addr", sram_address, a);
      end
      if (c == 4) begin
        check("t5_ready_after", req_ready, 1'b1);
        check("t5_select_after", sram_select, 1'b0);
      end
      if (c >= 2 && c < 6) begin
        check("t5_valid", resp_valid, 1'b1);
        check("t5_data", resp_data, DW'(160 + c - 2));
      end
      if (c == 6) check("t5_drained", resp_valid, 1'b0);
      @(negedge clk);
    end

    // 6: burst of 8 with resp_ready toggling
    for (int k = 0; k < 8; k++) wr(AW'(32 + k), DW'(512 + k));
    req_read_not_write = 1'b1;
    req_address        = 14'd32;
    nsel   = 0;
    rc     = 0;
    paused = 1'b0;
    for (int c = 0; c < 40; c++) begin
      req_valid     = (c == 0);
      req_burst_len = (c == 0) ? 4'd7 : 4'd0;
      resp_ready    = ((c % 2) == 0);
      #1;
      if (c == 0) check("t6_ready", req_ready, 1'b1);
      if (sram_select) begin
        check("t6_addr", sram_address, AW'(32 + nsel));
        check("t6_rnw", sram_read_not_write, 1'b1);
        nsel++;
      end else if (nsel > 0 && nsel < 8) begin
        paused = 1'b1;
      end
      if (resp_valid && resp_ready) begin
        check("t6_data", resp_data, DW'(512 + rc));
        rc++;
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    check("t6_beats", nsel, 8);
    check("t6_paused", paused, 1'b1);
    check("t6_returned", rc, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
